// File: rtl/sram_ro_axi_bridge.sv
// Read-only SRAM-style request responder: one burst at a time, issued as a single
// AXI AR transaction, with R beats streamed back as per-beat strobes.
module sram_ro_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd0,
  parameter logic [1:0] BURST  = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sram_req,
  input  logic [31:0] sram_addr,
  input  logic [3:0]  sram_len,
  input  logic [2:0]  sram_size,
  output logic        sram_addr_ok,
  output logic [31:0] sram_rdata,
  output logic        sram_rvalid,
  output logic        sram_data_ok,
  output logic [3:0]  axi_arid,
  output logic [31:0] axi_araddr,
  output logic [3:0]  axi_arlen,
  output logic [2:0]  axi_arsize,
  output logic [1:0]  axi_arburst,
  output logic [1:0]  axi_arlock,
  output logic [3:0]  axi_arcache,
  output logic [2:0]  axi_arprot,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  input  logic [3:0]  axi_rid,
  input  logic [31:0] axi_rdata,
  input  logic [1:0]  axi_rresp,
  input  logic        axi_rlast,
  input  logic        axi_rvalid,
  output logic        axi_rready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] addr_r;
  logic [3:0]  len_r;
  logic [2:0]  size_r;
  logic [3:0]  cnt_r;
  logic [31:0] rdata_r;
  logic        rvalid_r;
  logic        data_ok_r;
  logic        arvalid_s;
  logic        rready_s;
  logic        beat_s;
  logic        last_s;

  // rid and rresp are deliberately ignored: data is forwarded regardless of response.
  logic        unused_s;
  assign unused_s = ^{axi_rid, axi_rresp};

  // Next-state and handshake decode.
  always_comb begin
    state_nxt_s = state_r;
    arvalid_s   = 1'b0;
    rready_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (sram_req) begin
          state_nxt_s = ST_AR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_AR: begin
        arvalid_s = 1'b1;
        if (axi_arready) begin
          state_nxt_s = ST_R;
        end else begin
          state_nxt_s = ST_AR;
        end
      end
      ST_R: begin
        rready_s = 1'b1;
        if (last_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_R;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // A beat at the latched length ends the burst even if rlast never shows up.
  assign beat_s = axi_rvalid & rready_s;
  assign last_s = beat_s & (axi_rlast | (cnt_r == len_r));

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request capture, held stable for the whole AR phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_r <= 32'd0;
      len_r  <= 4'd0;
      size_r <= 3'd0;
    end else if (state_r == ST_IDLE && sram_req) begin
      addr_r <= sram_addr;
      len_r  <= sram_len;
      size_r <= sram_size;
    end
  end

  // Beat counter, cleared whenever idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= 4'd0;
    end else if (state_r == ST_IDLE) begin
      cnt_r <= 4'd0;
    end else if (beat_s) begin
      cnt_r <= cnt_r + 4'd1;
    end
  end

  // Registered return path: one-cycle latency, full throughput.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_r   <= 32'd0;
      rvalid_r  <= 1'b0;
      data_ok_r <= 1'b0;
    end else begin
      rvalid_r  <= beat_s;
      data_ok_r <= last_s;
      if (beat_s) begin
        rdata_r <= axi_rdata;
      end
    end
  end

  assign sram_addr_ok = arvalid_s & axi_arready;
  assign sram_rdata   = rdata_r;
  assign sram_rvalid  = rvalid_r;
  assign sram_data_ok = data_ok_r;
  assign axi_arid     = AXI_ID;
  assign axi_araddr   = addr_r;
  assign axi_arlen    = len_r;
  assign axi_arsize   = size_r;
  assign axi_arburst  = BURST;
  assign axi_arlock   = 2'd0;
  assign axi_arcache  = 4'd0;
  assign axi_arprot   = 3'd0;
  assign axi_arvalid  = arvalid_s;
  assign axi_rready   = rready_s;

endmodule

// File: tb/tb_sram_ro_axi_bridge.sv
// Directed bench for sram_ro_axi_bridge; returned beats are checked against a
// scoreboard queue filled when the bench drives each R beat.
module tb_sram_ro_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        sram_req;
  logic [31:0] sram_addr;
  logic [3:0]  sram_len;
  logic [2:0]  sram_size;
  logic        sram_addr_ok;
  logic [31:0] sram_rdata;
  logic        sram_rvalid;
  logic        sram_data_ok;
  logic [3:0]  axi_arid;
  logic [31:0] axi_araddr;
  logic [3:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic [1:0]  axi_arlock;
  logic [3:0]  axi_arcache;
  logic [2:0]  axi_arprot;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [3:0]  axi_rid;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast;
  logic        axi_rvalid;
  logic        axi_rready;

  sram_ro_axi_bridge dut (
    .clk(clk), .rst(rst),
    .sram_req(sram_req), .sram_addr(sram_addr), .sram_len(sram_len), .sram_size(sram_size),
    .sram_addr_ok(sram_addr_ok), .sram_rdata(sram_rdata), .sram_rvalid(sram_rvalid),
    .sram_data_ok(sram_data_ok),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_arlock(axi_arlock), .axi_arcache(axi_arcache),
    .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Return-path monitor: every sram_rvalid must match the next queued beat.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("data_ok_without_rvalid", {63'd0, sram_data_ok & ~sram_rvalid}, 64'd0);
      if (sram_rvalid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rvalid", 64'd1, 64'd0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("rdata", {32'd0, sram_rdata}, {32'd0, e.data});
          chk("data_ok", {63'd0, sram_data_ok}, {63'd0, e.last});
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one request; arready is held low for ar_wait cycles of the AR phase.
  task automatic do_req(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                        input int ar_wait);
    sram_req  = 1'b1;
    sram_addr = addr;
    sram_len  = len;
    sram_size = size;
    cyc();
    sram_addr = 32'hFFFF_FFFF;
    sram_len  = 4'hF;
    sram_size = 3'h7;
    for (int w = 0; w <= ar_wait; w++) begin
      axi_arready = (w == ar_wait);
      #4;
      chk("arvalid", {63'd0, axi_arvalid}, 64'd1);
      chk("araddr", {32'd0, axi_araddr}, {32'd0, addr});
      chk("arlen_size", {57'd0, axi_arlen, axi_arsize}, {57'd0, len, size});
      chk("addr_ok", {63'd0, sram_addr_ok}, {63'd0, (w == ar_wait)});
      chk("rready_in_ar", {63'd0, axi_rready}, 64'd0);
      cyc();
    end
    sram_req    = 1'b0;
    axi_arready = 1'b0;
    #1;
    chk("arvalid_after_hs", {63'd0, axi_arvalid}, 64'd0);
    chk("rready_in_r", {63'd0, axi_rready}, 64'd1);
  endtask

  // Drive n beats with up to max_gap idle cycles before each; exp_len is the
  // beat index that must be reported as last.
  task automatic send_beats(input int n, input logic [31:0] base, input bit use_rlast,
                            input int max_gap, input int last_idx);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = (max_gap == 0) ? 0 : $urandom_range(0, max_gap);
      for (int g = 0; g < gap; g++) begin
        axi_rvalid = 1'b0;
        axi_rdata  = $urandom;
        cyc();
      end
      axi_rvalid = 1'b1;
      axi_rdata  = base + 32'(i) * 32'h0101_0101;
      axi_rlast  = use_rlast && (i == last_idx);
      axi_rid    = 4'($urandom);
      axi_rresp  = 2'($urandom);
      #1;
      chk("rready_beat", {63'd0, axi_rready}, 64'd1);
      exp_q.push_back('{data: axi_rdata, last: (i == last_idx)});
      cyc();
    end
    axi_rvalid = 1'b0;
    axi_rlast  = 1'b0;
  endtask

  initial begin
    rst         = 1'b0;
    sram_req    = 1'b0;
    sram_addr   = 32'd0;
    sram_len    = 4'd0;
    sram_size   = 3'd0;
    axi_arready = 1'b0;
    axi_rid     = 4'd0;
    axi_rdata   = 32'd0;
    axi_rresp   = 2'd0;
    axi_rlast   = 1'b0;
    axi_rvalid  = 1'b0;

    // Reset held with random inputs: all outputs quiet.
    for (int i = 0; i < 4; i++) begin
      sram_req    = 1'($urandom);
      sram_addr   = $urandom;
      sram_len    = 4'($urandom);
      sram_size   = 3'($urandom);
      axi_arready = 1'($urandom);
      axi_rvalid  = 1'($urandom);
      axi_rlast   = 1'($urandom);
      axi_rdata   = $urandom;
      cyc();
      #3;
      chk("rst_ctrl", {59'd0, sram_addr_ok, sram_rvalid, sram_data_ok, axi_arvalid, axi_rready}, 64'd0);
      chk("rst_data", {sram_rdata, axi_araddr}, 64'd0);
      chk("rst_fields", {53'd0, axi_arlen, axi_arsize, axi_arlock, axi_arcache}, 64'd0);
      chk("const_fields", {55'd0, axi_arid, axi_arburst, axi_arprot}, {55'd0, 4'd0, 2'b01, 3'd0});
    end
    sram_req    = 1'b0;
    axi_arready = 1'b0;
    axi_rvalid  = 1'b0;
    axi_rlast   = 1'b0;
    cyc();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("idle_no_arvalid", {63'd0, axi_arvalid}, 64'd0);
    end

    // Single beat, arready immediate.
    do_req(32'h1FC0_0000, 4'd0, 3'd2, 0);
    axi_rvalid = 1'b1;
    axi_rdata  = 32'hDEAD_BEEF;
    axi_rlast  = 1'b1;
    #1;
    chk("rready_single", {63'd0, axi_rready}, 64'd1);
    exp_q.push_back('{data: 32'hDEAD_BEEF, last: 1'b1});
    cyc();
    axi_rvalid = 1'b0;
    axi_rlast  = 1'b0;
    chk("idle_after_single", {63'd0, axi_rready}, 64'd0);
    cyc();

    // 8-beat burst with random gaps, then back-to-back 4-beat burst.
    do_req(32'h0000_1000, 4'd7, 3'd2, 0);
    send_beats(8, 32'h1000_0000, 1'b1, 2, 7);
    chk("idle_after_8", {62'd0, axi_rready, axi_arvalid}, 64'd0);
    cyc();
    do_req(32'h0000_2040, 4'd3, 3'd2, 0);
    send_beats(4, 32'hA000_0000, 1'b1, 0, 3);
    chk("idle_after_b2b", {63'd0, axi_rready}, 64'd0);
    cyc();

    // Arready backpressure for 5 cycles.
    do_req(32'h8000_0010, 4'd1, 3'd2, 5);
    send_beats(2, 32'h5500_0000, 1'b1, 1, 1);
    cyc();

    // Missing rlast: length limit closes the burst, extra beat is refused.
    do_req(32'h0000_3000, 4'd3, 3'd2, 0);
    send_beats(4, 32'h3300_0000, 1'b0, 1, 3);
    axi_rvalid = 1'b1;
    axi_rdata  = 32'hBAD0_BAD0;
    #1;
    chk("rready_after_missing_rlast", {63'd0, axi_rready}, 64'd0);
    cyc();
    axi_rvalid = 1'b0;
    cyc();

    // Reset after beat 2 of 8, then a clean request.
    do_req(32'h0000_4000, 4'd7, 3'd2, 0);
    send_beats(2, 32'h4400_0000, 1'b1, 0, 7);
    cyc();
    cyc();
    chk("beats_before_reset", 64'(exp_q.size()), 64'd0);
    rst = 1'b0;
    #2;
    chk("midrst_ctrl", {59'd0, sram_addr_ok, sram_rvalid, sram_data_ok, axi_arvalid, axi_rready}, 64'd0);
    chk("midrst_data", {sram_rdata, axi_araddr}, 64'd0);
    exp_q.delete();
    cyc();
    rst = 1'b1;
    cyc();
    do_req(32'h0000_5000, 4'd1, 3'd2, 1);
    send_beats(2, 32'h7700_0000, 1'b1, 0, 1);
    cyc();
    cyc();

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
